// File: rtl/frame_buf_ctrl_if.sv
// ---------------------------------------------------------------------------
// frame_buf_ctrl_if
// Bundles the signals of frame_buf_ctrl: two 4-bit pixel streams (left and
// right valid/data/ready), the shared buffer write port (wen/waddr/wdata) and
// the SAD core handshake (start/bank/done).
//   modport slave  : the controller side (accepts streams, drives buffer/SAD)
//   modport master : the environment side (stream sources, buffer, SAD core)
// ---------------------------------------------------------------------------
interface frame_buf_ctrl_if #(
  parameter int BUF_ADDR_WIDTH = 32
) ();
  logic                      l_wvalid;
  logic [3:0]                l_wdata;
  logic                      l_wready;
  logic                      r_wvalid;
  logic [3:0]                r_wdata;
  logic                      r_wready;
  logic                      mem_wen;
  logic [BUF_ADDR_WIDTH-1:0] mem_waddr;
  logic [3:0]                mem_wdata;
  logic                      sad_start;
  logic                      sad_bank;
  logic                      sad_done;

  modport slave (
    input  l_wvalid, l_wdata, r_wvalid, r_wdata, sad_done,
    output l_wready, r_wready, mem_wen, mem_waddr, mem_wdata, sad_start, sad_bank
  );

  modport master (
    output l_wvalid, l_wdata, r_wvalid, r_wdata, sad_done,
    input  l_wready, r_wready, mem_wen, mem_waddr, mem_wdata, sad_start, sad_bank
  );
endinterface

// File: rtl/frame_buf_ctrl.sv
// ---------------------------------------------------------------------------
// frame_buf_ctrl
// Ping-pong frame buffer controller for the stereo SAD pipeline. Left and right
// 4-bit mean-pixel streams are arbitrated round-robin onto one buffer write
// port. Two banks each hold one left and one right frame; when a bank holds a
// complete pair the SAD engine is started on it, and the bank is freed again
// on sad_done.
// Ports:
//   clk    : sole clock
//   rst_n  : asynchronous active-low reset
//   bus    : frame_buf_ctrl_if.slave
//            l_/r_ wvalid,wdata,wready : pixel streams (ready is combinational,
//                                        independent of the stream's own valid)
//            mem_wen/waddr/wdata       : registered buffer write, 1 cycle after
//                                        the handshake
//            sad_start/sad_bank/sad_done : SAD core handshake
// Address map: region = bank*2 + side (left 0, right 1),
//              address = region*FRAME_PIXELS + pixel count of that side.
// ---------------------------------------------------------------------------
module frame_buf_ctrl #(
  parameter int CAMERA_HSIZE   = 100,
  parameter int CAMERA_VSIZE   = 100,
  parameter int BUF_ADDR_WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  frame_buf_ctrl_if.slave  bus
);

  localparam int FRAME_PIXELS = CAMERA_HSIZE * CAMERA_VSIZE;
  localparam int CNT_W        = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  localparam logic [CNT_W-1:0]          CNT_LAST = CNT_W'(FRAME_PIXELS - 1);
  localparam logic [BUF_ADDR_WIDTH-1:0] FP_A     = BUF_ADDR_WIDTH'(FRAME_PIXELS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } sched_e;

  // done_q[b][s]: side s finished writing bank b
  logic [1:0][1:0]     done_q;
  logic [1:0]          busy_q;
  logic                l_wb_q, r_wb_q;
  logic [CNT_W-1:0]    l_cnt_q, r_cnt_q;
  logic                last_q;          // 0: left granted last, 1: right
  logic                rb_q;
  sched_e              state_q, state_d;
  logic                set_busy, release_bank;

  logic                l_ok, r_ok, l_hs, r_hs;

  logic                      wen_p1;
  logic [BUF_ADDR_WIDTH-1:0] waddr_p1;
  logic [3:0]                wdata_p1;

  function automatic logic [BUF_ADDR_WIDTH-1:0] wr_addr(
    input logic             bank,
    input logic             side,
    input logic [CNT_W-1:0] cnt
  );
    return BUF_ADDR_WIDTH'({bank, side}) * FP_A + BUF_ADDR_WIDTH'(cnt);
  endfunction

  // A side may write when its current bank is neither pending nor being read.
  assign l_ok = !done_q[l_wb_q][0] && !busy_q[l_wb_q];
  assign r_ok = !done_q[r_wb_q][1] && !busy_q[r_wb_q];

  // Round-robin: yield to the other side only if it was not granted last and
  // is actually competing this cycle.
  assign bus.l_wready = l_ok && (last_q || !bus.r_wvalid || !r_ok);
  assign bus.r_wready = r_ok && (!last_q || !bus.l_wvalid || !l_ok);

  assign l_hs = bus.l_wvalid && bus.l_wready;
  assign r_hs = bus.r_wvalid && bus.r_wready;

  // Stream side state: pixel counters, write banks and arbitration pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_cnt_q <= '0;
      r_cnt_q <= '0;
      l_wb_q  <= 1'b0;
      r_wb_q  <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      if (l_hs) begin
        last_q <= 1'b0;
        if (l_cnt_q == CNT_LAST) begin
          l_cnt_q <= '0;
          l_wb_q  <= ~l_wb_q;
        end else begin
          l_cnt_q <= l_cnt_q + CNT_W'(1);
        end
      end
      if (r_hs) begin
        last_q <= 1'b1;
        if (r_cnt_q == CNT_LAST) begin
          r_cnt_q <= '0;
          r_wb_q  <= ~r_wb_q;
        end else begin
          r_cnt_q <= r_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // Bank state. The released bank is always busy, so no side can complete a
  // frame into it in the same cycle; set and clear never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= '0;
      busy_q <= '0;
    end else begin
      if (set_busy) begin
        busy_q[rb_q] <= 1'b1;
      end
      if (release_bank) begin
        busy_q[rb_q] <= 1'b0;
        done_q[rb_q] <= 2'b00;
      end
      if (l_hs && (l_cnt_q == CNT_LAST)) begin
        done_q[l_wb_q][0] <= 1'b1;
      end
      if (r_hs && (r_cnt_q == CNT_LAST)) begin
        done_q[r_wb_q][1] <= 1'b1;
      end
    end
  end

  // SAD scheduler
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (release_bank) begin
        rb_q <= ~rb_q;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    set_busy     = 1'b0;
    release_bank = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (done_q[rb_q] == 2'b11) begin
          state_d = S_START;
        end
      end
      S_START: begin
        set_busy = 1'b1;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (bus.sad_done) begin
          release_bank = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.sad_start = (state_q == S_START);
  assign bus.sad_bank  = rb_q;

  // Stage p1: registered buffer write (at most one grant per cycle)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_p1   <= 1'b0;
      waddr_p1 <= '0;
      wdata_p1 <= '0;
    end else begin
      wen_p1 <= l_hs || r_hs;
      if (l_hs) begin
        waddr_p1 <= wr_addr(l_wb_q, 1'b0, l_cnt_q);
        wdata_p1 <= bus.l_wdata;
      end else if (r_hs) begin
        waddr_p1 <= wr_addr(r_wb_q, 1'b1, r_cnt_q);
        wdata_p1 <= bus.r_wdata;
      end
    end
  end

  assign bus.mem_wen   = wen_p1;
  assign bus.mem_waddr = waddr_p1;
  assign bus.mem_wdata = wdata_p1;

endmodule

// File: tb/tb_frame_buf_ctrl.sv
// ---------------------------------------------------------------------------
// tb_frame_buf_ctrl
// Directed scenarios with constant expectations for a 4x2 frame, followed by
// randomized streams checked each cycle against a behavioural model of the
// banks, pixel counts, arbitration and SAD scheduling.
// ---------------------------------------------------------------------------
module tb_frame_buf_ctrl;
  localparam int HS = 4;
  localparam int VS = 2;
  localparam int FP = HS * VS;
  localparam int AW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  frame_buf_ctrl_if #(.BUF_ADDR_WIDTH(AW)) bus ();

  frame_buf_ctrl #(
    .CAMERA_HSIZE(HS), .CAMERA_VSIZE(VS), .BUF_ADDR_WIDTH(AW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // behavioural model state
  int m_done [2][2];
  int m_busy [2];
  int m_wb   [2];
  int m_cnt  [2];
  int m_last;
  int m_rb;
  int m_phase;   // 0 idle, 1 start, 2 wait

  logic e_lrdy, e_rrdy, e_wen, e_start;
  int   e_waddr, e_wdata;
  logic a_lrdy, a_rrdy;

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      m_busy[b] = 0;
      m_wb[b]   = 0;
      m_cnt[b]  = 0;
      for (int s = 0; s < 2; s++) m_done[b][s] = 0;
    end
    m_last = 1; m_rb = 0; m_phase = 0;
    e_wen = 1'b0; e_start = 1'b0; e_waddr = 0; e_wdata = 0;
  endtask

  function automatic int writable(int s);
    return (m_done[m_wb[s]][s] == 0 && m_busy[m_wb[s]] == 0) ? 1 : 0;
  endfunction

  // One clock: sample readies away from the edge, predict, advance the model.
  task automatic tick();
    int lv, rv, ld, rd, dn, side, dat;
    int ok_l, ok_r;
    #1;
    a_lrdy = bus.l_wready;
    a_rrdy = bus.r_wready;
    lv = int'(bus.l_wvalid); rv = int'(bus.r_wvalid);
    ld = int'(bus.l_wdata);  rd = int'(bus.r_wdata);
    dn = int'(bus.sad_done);
    ok_l = writable(0);
    ok_r = writable(1);
    e_lrdy = (ok_l == 1) && (m_last == 1 || rv == 0 || ok_r == 0);
    e_rrdy = (ok_r == 1) && (m_last == 0 || lv == 0 || ok_l == 0);
    side = -1; dat = 0;
    if (lv == 1 && e_lrdy) begin side = 0; dat = ld; end
    else if (rv == 1 && e_rrdy) begin side = 1; dat = rd; end
    @(posedge clk);
    if (m_phase == 0) begin
      if (m_done[m_rb][0] == 1 && m_done[m_rb][1] == 1) m_phase = 1;
    end else if (m_phase == 1) begin
      m_busy[m_rb] = 1;
      m_phase = 2;
    end else if (dn == 1) begin
      m_done[m_rb][0] = 0;
      m_done[m_rb][1] = 0;
      m_busy[m_rb] = 0;
      m_rb = 1 - m_rb;
      m_phase = 0;
    end
    e_wen = 1'b0;
    if (side >= 0) begin
      e_wen   = 1'b1;
      e_waddr = (m_wb[side] * 2 + side) * FP + m_cnt[side];
      e_wdata = dat;
      m_last  = side;
      if (m_cnt[side] == FP - 1) begin
        m_cnt[side] = 0;
        m_done[m_wb[side]][side] = 1;
        m_wb[side] = 1 - m_wb[side];
      end else begin
        m_cnt[side]++;
      end
    end
    e_start = (m_phase == 1);
    #1;
  endtask

  task automatic idle_inputs();
    bus.l_wvalid = 1'b0; bus.r_wvalid = 1'b0;
    bus.l_wdata = 4'h0;  bus.r_wdata = 4'h0;
    bus.sad_done = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.l_wready, bus.r_wready} !== 2'b11) begin
      errors++; $display("FAIL reset_ready got %b expected 11", {bus.l_wready, bus.r_wready});
    end
    checks++;
    if (bus.mem_wen !== 1'b0 || bus.mem_waddr !== AW'(0) || bus.mem_wdata !== 4'h0) begin
      errors++; $display("FAIL reset_mem got wen=%b addr=%0d data=%h expected 0/0/0",
                         bus.mem_wen, bus.mem_waddr, bus.mem_wdata);
    end
    checks++;
    if (bus.sad_start !== 1'b0 || bus.sad_bank !== 1'b0) begin
      errors++; $display("FAIL reset_sad got start=%b bank=%b expected 0/0", bus.sad_start, bus.sad_bank);
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_left_only();
    apply_reset();
    for (int i = 0; i < FP; i++) begin
      bus.l_wvalid = 1'b1; bus.l_wdata = 4'h5;
      tick();
      checks++;
      if (a_lrdy !== 1'b1) begin
        errors++; $display("FAIL left_only_ready px%0d got %b expected 1", i, a_lrdy);
      end
      checks++;
      if (bus.mem_wen !== 1'b1 || bus.mem_waddr !== AW'(i) || bus.mem_wdata !== 4'h5) begin
        errors++; $display("FAIL left_only_write px%0d got wen=%b addr=%0d data=%h expected 1/%0d/5",
                           i, bus.mem_wen, bus.mem_waddr, bus.mem_wdata, i);
      end
    end
    bus.l_wvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus.mem_wen !== 1'b0 || bus.sad_start !== 1'b0) begin
        errors++; $display("FAIL left_only_quiet cyc%0d got wen=%b start=%b expected 0/0",
                           i, bus.mem_wen, bus.sad_start);
      end
    end
    // left moved on to the free bank 1, so it stays ready
    checks++;
    if (a_lrdy !== 1'b1) begin
      errors++; $display("FAIL left_only_bank1_ready got %b expected 1", a_lrdy);
    end
  endtask

  // Both streams valid every cycle until both banks are full and stalled.
  task automatic test_alternate_fill();
    int j, side, addr;
    logic [3:0] ld, rd, dat;
    apply_reset();
    for (int t = 0; t < 42; t++) begin
      ld = 4'($urandom); rd = 4'($urandom);
      bus.l_wvalid = 1'b1; bus.r_wvalid = 1'b1;
      bus.l_wdata = ld;    bus.r_wdata = rd;
      tick();
      checks++;
      if ({a_lrdy, a_rrdy} !== {(t < 32) && (t % 2 == 0), (t < 32) && (t % 2 == 1)}) begin
        errors++; $display("FAIL alt_ready t%0d got %b%b", t, a_lrdy, a_rrdy);
      end
      if (t < 32) begin
        side = t % 2; j = t / 2;
        addr = (j < 8) ? (side * 8 + j) : (16 + side * 8 + (j - 8));
        dat  = (side == 0) ? ld : rd;
        checks++;
        if (bus.mem_wen !== 1'b1 || bus.mem_waddr !== AW'(addr) || bus.mem_wdata !== dat) begin
          errors++; $display("FAIL alt_write t%0d got wen=%b addr=%0d data=%h expected 1/%0d/%h",
                             t, bus.mem_wen, bus.mem_waddr, bus.mem_wdata, addr, dat);
        end
      end else begin
        checks++;
        if (bus.mem_wen !== 1'b0) begin
          errors++; $display("FAIL alt_stall_wen t%0d got %b expected 0", t, bus.mem_wen);
        end
      end
      checks++;
      if (bus.sad_start !== (t == 16) || bus.sad_bank !== 1'b0) begin
        errors++; $display("FAIL alt_sad t%0d got start=%b bank=%b expected %b/0",
                           t, bus.sad_start, bus.sad_bank, (t == 16));
      end
    end
  endtask

  // Continues from the stalled state left by test_alternate_fill.
  task automatic test_stall_release();
    bus.l_wvalid = 1'b1; bus.r_wvalid = 1'b1; bus.sad_done = 1'b1;
    tick();
    bus.sad_done = 1'b0;
    checks++;
    if ({a_lrdy, a_rrdy} !== 2'b00 || bus.mem_wen !== 1'b0) begin
      errors++; $display("FAIL release_done_cycle got rdy=%b%b wen=%b expected 00/0", a_lrdy, a_rrdy, bus.mem_wen);
    end
    bus.l_wvalid = 1'b0; bus.r_wvalid = 1'b0;
    tick();
    checks++;
    if ({a_lrdy, a_rrdy} !== 2'b11) begin
      errors++; $display("FAIL release_ready got %b%b expected 11", a_lrdy, a_rrdy);
    end
    checks++;
    if (bus.sad_start !== 1'b1 || bus.sad_bank !== 1'b1) begin
      errors++; $display("FAIL release_start got start=%b bank=%b expected 1/1", bus.sad_start, bus.sad_bank);
    end
    bus.l_wvalid = 1'b1; bus.r_wvalid = 1'b1; bus.l_wdata = 4'hA; bus.r_wdata = 4'h3;
    tick();
    checks++;
    if (bus.mem_wen !== 1'b1 || bus.mem_waddr !== AW'(0) || bus.mem_wdata !== 4'hA || bus.sad_start !== 1'b0) begin
      errors++; $display("FAIL release_left_write got wen=%b addr=%0d data=%h start=%b expected 1/0/a/0",
                         bus.mem_wen, bus.mem_waddr, bus.mem_wdata, bus.sad_start);
    end
    tick();
    checks++;
    if (bus.mem_wen !== 1'b1 || bus.mem_waddr !== AW'(8) || bus.mem_wdata !== 4'h3) begin
      errors++; $display("FAIL release_right_write got wen=%b addr=%0d data=%h expected 1/8/3",
                         bus.mem_wen, bus.mem_waddr, bus.mem_wdata);
    end
    idle_inputs();
  endtask

  task automatic test_spurious_done();
    apply_reset();
    bus.sad_done = 1'b1;
    tick();
    bus.sad_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({a_lrdy, a_rrdy} !== 2'b11 || bus.sad_start !== 1'b0 || bus.sad_bank !== 1'b0 || bus.mem_wen !== 1'b0) begin
        errors++; $display("FAIL spurious_idle cyc%0d got rdy=%b%b start=%b bank=%b wen=%b expected 11/0/0/0",
                           i, a_lrdy, a_rrdy, bus.sad_start, bus.sad_bank, bus.mem_wen);
      end
    end
    // a full pair afterwards must still start on bank 0
    for (int t = 0; t < 18; t++) begin
      bus.l_wvalid = (t < 16); bus.r_wvalid = (t < 16);
      tick();
      checks++;
      if (bus.sad_start !== (t == 16) || bus.sad_bank !== 1'b0) begin
        errors++; $display("FAIL spurious_pair t%0d got start=%b bank=%b expected %b/0",
                           t, bus.sad_start, bus.sad_bank, (t == 16));
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      bus.l_wvalid = 1'b1; bus.l_wdata = 4'h9;
      tick();
    end
    bus.l_wvalid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.mem_wen !== 1'b0 || bus.mem_waddr !== AW'(0) || bus.mem_wdata !== 4'h0) begin
      errors++; $display("FAIL midreset_async got wen=%b addr=%0d data=%h expected 0/0/0",
                         bus.mem_wen, bus.mem_waddr, bus.mem_wdata);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({bus.l_wready, bus.r_wready, bus.sad_start, bus.sad_bank, bus.mem_wen} !== 5'b11000) begin
      errors++; $display("FAIL midreset_hold got rdy=%b%b start=%b bank=%b wen=%b expected 11/0/0/0",
                         bus.l_wready, bus.r_wready, bus.sad_start, bus.sad_bank, bus.mem_wen);
    end
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < FP; i++) begin
      bus.l_wvalid = 1'b1; bus.l_wdata = 4'(i);
      tick();
      checks++;
      if (bus.mem_wen !== 1'b1 || bus.mem_waddr !== AW'(i) || bus.mem_wdata !== 4'(i)) begin
        errors++; $display("FAIL midreset_restart px%0d got wen=%b addr=%0d data=%h expected 1/%0d/%h",
                           i, bus.mem_wen, bus.mem_waddr, bus.mem_wdata, i, 4'(i));
      end
    end
    idle_inputs();
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 4000; c++) begin
      if (c == 2000) begin
        // abandon whatever is in flight
        apply_reset();
      end
      bus.l_wvalid = ($urandom_range(0, 3) != 0);
      bus.r_wvalid = ($urandom_range(0, 3) != 0);
      bus.l_wdata  = 4'($urandom);
      bus.r_wdata  = 4'($urandom);
      bus.sad_done = ($urandom_range(0, 11) == 0);
      tick();
      checks++;
      if (a_lrdy !== e_lrdy || a_rrdy !== e_rrdy) begin
        errors++; $display("FAIL rand_ready c%0d got %b%b expected %b%b", c, a_lrdy, a_rrdy, e_lrdy, e_rrdy);
      end
      checks++;
      if (bus.mem_wen !== e_wen ||
          (e_wen && (bus.mem_waddr !== AW'(e_waddr) || bus.mem_wdata !== 4'(e_wdata)))) begin
        errors++; $display("FAIL rand_write c%0d got wen=%b addr=%0d data=%h expected %b/%0d/%h",
                           c, bus.mem_wen, bus.mem_waddr, bus.mem_wdata, e_wen, e_waddr, 4'(e_wdata));
      end
      checks++;
      if (bus.sad_start !== e_start || bus.sad_bank !== m_rb[0]) begin
        errors++; $display("FAIL rand_sad c%0d got start=%b bank=%b expected %b/%0d",
                           c, bus.sad_start, bus.sad_bank, e_start, m_rb);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    model_reset();
    test_reset();
    test_left_only();
    test_alternate_fill();
    test_stall_release();
    test_spurious_done();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
